// File: rtl/fwd_pkg.sv
// Shared types for the operand forwarding controller:
// pipeline tag bundle and the operand-mux select encoding.
package fwd_pkg;

  localparam int FWD_RD_W = 8;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } fwd_tag_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_MEM    = 2'd1,
    FWD_WB     = 2'd2,
    FWD_WBHOLD = 2'd3
  } fwd_sel_e;

  function automatic logic fwd_hit(
    input fwd_tag_t            t,
    input logic [FWD_RD_W-1:0] s
  );
    return t.valid & t.reg_write & (t.rd == s);
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// One source specifier against the EX/MEM/WB tags:
// youngest-first select plus a load-in-EX hit flag.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_BITS-1:0] src,
  input  logic                used,
  input  fwd_tag_t            ex_t,
  input  fwd_tag_t            mem_t,
  input  fwd_tag_t            wb_t,
  output fwd_sel_e            sel,
  output logic                ld_hit
);

  logic [FWD_RD_W-1:0] s;
  logic                live;
  logic                hit_ex;
  logic                hit_mem;
  logic                hit_wb;

  assign s    = FWD_RD_W'(src);
  assign live = used & (src != REG_BITS'(ZERO_REG));

  assign hit_ex  = live & fwd_hit(ex_t, s);
  assign hit_mem = live & fwd_hit(mem_t, s);
  assign hit_wb  = live & fwd_hit(wb_t, s);

  assign ld_hit = hit_ex & ex_t.mem_read;

  // youngest producer wins
  always_comb begin
    sel = FWD_RF;
    if (hit_ex)
      sel = FWD_MEM;
    else if (hit_mem)
      sel = FWD_WB;
    else if (hit_wb)
      sel = FWD_WBHOLD;
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// EX operand forwarding select and load-use stall generator.
// Optional stall counter enabled by FWD_STALL_CNT_EN.
module operand_fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_BITS  = 5,
  parameter int ZERO_REG  = 31,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic [REG_BITS-1:0]  dec_rn,
  input  logic [REG_BITS-1:0]  dec_rm,
  input  logic                 dec_rn_used,
  input  logic                 dec_rm_used,
  input  logic [REG_BITS-1:0]  dec_rd,
  input  logic                 dec_reg_write,
  input  logic                 dec_mem_read,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [1:0]           ex_sel_a,
  output logic [1:0]           ex_sel_b,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  fwd_tag_t ex_t_q, ex_t_d;
  fwd_tag_t mem_t_q;
  fwd_tag_t wb_t_q;
  fwd_sel_e ex_sel_a_q, ex_sel_a_d;
  fwd_sel_e ex_sel_b_q, ex_sel_b_d;
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;
  logic     ld_a;
  logic     ld_b;
  logic     issue;

  fwd_src_cmp #(
    .REG_BITS(REG_BITS),
    .ZERO_REG(ZERO_REG)
  ) u_cmp_a (
    .src   (dec_rn),
    .used  (dec_rn_used),
    .ex_t  (ex_t_q),
    .mem_t (mem_t_q),
    .wb_t  (wb_t_q),
    .sel   (sel_a),
    .ld_hit(ld_a)
  );

  fwd_src_cmp #(
    .REG_BITS(REG_BITS),
    .ZERO_REG(ZERO_REG)
  ) u_cmp_b (
    .src   (dec_rm),
    .used  (dec_rm_used),
    .ex_t  (ex_t_q),
    .mem_t (mem_t_q),
    .wb_t  (wb_t_q),
    .sel   (sel_b),
    .ld_hit(ld_b)
  );

  assign stall = dec_valid & ~flush & (ld_a | ld_b);
  assign issue = dec_valid & ~flush & ~stall;

  // next EX tag and selects; flush, stall and idle all give a bubble
  always_comb begin
    ex_t_d     = '0;
    ex_sel_a_d = FWD_RF;
    ex_sel_b_d = FWD_RF;
    if (issue) begin
      ex_t_d.valid     = 1'b1;
      ex_t_d.rd        = FWD_RD_W'(dec_rd);
      ex_t_d.reg_write = dec_reg_write;
      ex_t_d.mem_read  = dec_mem_read;
      ex_sel_a_d       = sel_a;
      ex_sel_b_d       = sel_b;
    end
  end

  // tag pipeline and registered selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_t_q     <= '0;
      mem_t_q    <= '0;
      wb_t_q     <= '0;
      ex_sel_a_q <= FWD_RF;
      ex_sel_b_q <= FWD_RF;
    end else begin
      ex_t_q     <= ex_t_d;
      mem_t_q    <= ex_t_q;
      wb_t_q     <= mem_t_q;
      ex_sel_a_q <= ex_sel_a_d;
      ex_sel_b_q <= ex_sel_b_d;
    end
  end

  assign ex_valid = ex_t_q.valid;
  assign ex_sel_a = ex_sel_a_q;
  assign ex_sel_b = ex_sel_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // saturating stall-cycle count
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
